// File: rtl/sram_array_ctrl_pkg.sv
// sram_pkg: shared types and sizing helpers for the banked SRAM controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default geometry (NUM_BANK, NUM_SLICE, BE_W, SLICE_BE_W for the
// 64b x 64-word build), FSM encoding, and helpers that derive geometry from
// the parameters of a particular instance.
package sram_pkg;

    localparam int DW_DEF       = 64;
    localparam int SLICE_DW_DEF = 32;
    localparam int AW_DEF       = 6;
    localparam int BANK_AW_DEF  = 4;

    localparam int NUM_BANK   = 2 ** (AW_DEF - BANK_AW_DEF);
    localparam int NUM_SLICE  = DW_DEF / SLICE_DW_DEF;
    localparam int BE_W       = DW_DEF / 8;
    localparam int SLICE_BE_W = SLICE_DW_DEF / 8;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    function automatic int num_bank(input int aw, input int bank_aw);
        return 2 ** (aw - bank_aw);
    endfunction

    function automatic int num_slice(input int dw, input int slice_dw);
        return dw / slice_dw;
    endfunction

    function automatic int bytes_of(input int w);
        return w / 8;
    endfunction

endpackage

// File: rtl/sram_array_ctrl_spsram_be.sv
// spsram_be: single-port synchronous RAM macro model with per-byte write mask.
// Latency: read data registered, valid the cycle after an enabled read.
// Backpressure: none; one access per enabled cycle.
// Ports: clk, ce (enable), we (1=write), addr, wdata, be (byte mask), rdata.
// rdata holds its value on writes and idle cycles; mem is not reset.
module spsram_be
    import sram_pkg::*;
#(
    parameter int SLICE_DW = 32,
    parameter int BANK_AW  = 4
) (
    input  logic                        clk,
    input  logic                        ce,
    input  logic                        we,
    input  logic [BANK_AW-1:0]          addr,
    input  logic [SLICE_DW-1:0]         wdata,
    input  logic [bytes_of(SLICE_DW)-1:0] be,
    output logic [SLICE_DW-1:0]         rdata
);

    localparam int NB = bytes_of(SLICE_DW);

    logic [SLICE_DW-1:0] mem [2**BANK_AW];

    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                for (int k = 0; k < NB; k++) begin
                    if (be[k]) begin
                        mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_array_ctrl.sv
// sram_array_ctrl: one logical SRAM built from NUM_BANK x NUM_SLICE macros.
// Latency: read accepted in cycle N -> o_rvalid/o_rdata in cycle N+2; writes land at the accepting edge.
// Backpressure: o_ready low only during reset and the zero-fill sweep; never stalls in IDLE.
// Ports: i_clk/i_rstn; request i_req/o_ready with i_wen, i_addr, i_data, i_be;
// read response o_rdata/o_rvalid; o_busy_init during the sweep; o_bank_sel one-hot
// chip enable of the access accepted this cycle.
module sram_array_ctrl
    import sram_pkg::*;
#(
    parameter int DW       = 64,
    parameter int SLICE_DW = 32,
    parameter int AW       = 6,
    parameter int BANK_AW  = 4,
    parameter int INIT_EN  = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_req,
    output logic                         o_ready,
    input  logic                         i_wen,
    input  logic [AW-1:0]                i_addr,
    input  logic [DW-1:0]                i_data,
    input  logic [DW/8-1:0]              i_be,
    output logic [DW-1:0]                o_rdata,
    output logic                         o_rvalid,
    output logic                         o_busy_init,
    output logic [2**(AW-BANK_AW)-1:0]   o_bank_sel
);

    localparam int N_BANK = num_bank(AW, BANK_AW);
    localparam int N_SLICE = num_slice(DW, SLICE_DW);
    localparam int N_BE   = bytes_of(DW);
    localparam int N_SBE  = bytes_of(SLICE_DW);
    localparam int BSEL_W = AW - BANK_AW;

    state_t               state;
    state_t               state_nxt;
    logic [BANK_AW-1:0]   init_cnt;
    logic                 ready_q;
    logic                 init_last;
    logic                 accept;
    logic                 rd_accept;
    logic [BSEL_W-1:0]    bank;

    logic [N_BANK-1:0]    mac_ce;
    logic                 mac_we;
    logic [BANK_AW-1:0]   mac_addr;
    logic [DW-1:0]        mac_wdata;
    logic [N_BE-1:0]      mac_be;
    logic [SLICE_DW-1:0]  mac_rdata [N_BANK][N_SLICE];

    logic                 rd_p1;
    logic [BSEL_W-1:0]    rd_bank;
    logic [DW-1:0]        rd_mux;

    assign bank      = i_addr[AW-1:BANK_AW];
    assign init_last = (init_cnt == {BANK_AW{1'b1}});
    // ready is registered so it is low throughout reset even when the FSM
    // resets straight into IDLE; it follows the next state one edge later.
    assign o_ready   = ready_q;
    assign accept    = i_req & ready_q;
    assign rd_accept = accept & ~i_wen;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            if (INIT_EN != 0) begin
                state <= INIT;
            end else begin
                state <= IDLE;
            end
            init_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE);
            if (state == INIT) begin
                init_cnt <= init_cnt + BANK_AW'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_last) state_nxt = IDLE;
            IDLE:    state_nxt = IDLE;
            default: state_nxt = state;
        endcase
    end

    // Output / macro control logic
    always_comb begin
        o_busy_init = 1'b0;
        o_bank_sel  = '0;
        mac_ce      = '0;
        mac_we      = 1'b0;
        mac_addr    = i_addr[BANK_AW-1:0];
        mac_wdata   = i_data;
        mac_be      = i_be;
        case (state)
            INIT: begin
                // Every macro shares the sweep address, so all banks clear in parallel.
                o_busy_init = 1'b1;
                mac_ce      = '1;
                mac_we      = 1'b1;
                mac_addr    = init_cnt;
                mac_wdata   = '0;
                mac_be      = '1;
            end
            IDLE: begin
                if (accept) begin
                    mac_ce     = N_BANK'(1) << bank;
                    mac_we     = i_wen;
                    o_bank_sel = N_BANK'(1) << bank;
                end
            end
            default: ;
        endcase
    end

    for (genvar b = 0; b < N_BANK; b++) begin : g_bank
        for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
            spsram_be #(
                .SLICE_DW (SLICE_DW),
                .BANK_AW  (BANK_AW)
            ) u_mem (
                .clk   (i_clk),
                .ce    (mac_ce[b]),
                .we    (mac_we),
                .addr  (mac_addr),
                .wdata (mac_wdata[s*SLICE_DW +: SLICE_DW]),
                .be    (mac_be[s*N_SBE +: N_SBE]),
                .rdata (mac_rdata[b][s])
            );
        end
    end

    // The macro registers its data at the accepting edge; the bank that
    // produced it is remembered here so the mux picks the right one next cycle.
    always_comb begin
        rd_mux = '0;
        for (int s = 0; s < N_SLICE; s++) begin
            rd_mux[s*SLICE_DW +: SLICE_DW] = mac_rdata[rd_bank][s];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_p1    <= 1'b0;
            rd_bank  <= '0;
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
        end else begin
            rd_p1    <= rd_accept;
            o_rvalid <= rd_p1;
            if (rd_accept) begin
                rd_bank <= bank;
            end
            if (rd_p1) begin
                o_rdata <= rd_mux;
            end
        end
    end

endmodule
